// File: rtl/div_hilo_ctrl.sv
// Multi-cycle restoring divide sequencer for MIPS DIV/DIVU.
// Stalls the pipeline while running and issues a one-cycle HILO write when it finishes.
module div_hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall_req,
    output logic             busy,
    output logic             div_HILO_enabler,
    output logic [WIDTH-1:0] div_HILO_HI,
    output logic [WIDTH-1:0] div_HILO_LO
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic             busy_reg, busy_next;

    logic             a_neg, b_neg, no_borrow;
    logic [WIDTH-1:0] a_mag, b_mag, rem_step, quo_step;
    logic [WIDTH:0]   rem_sh, trial;

    // Operand magnitudes and one restoring step on the current partial remainder.
    always_comb begin
        a_neg     = signed_op & dividend[WIDTH-1];
        b_neg     = signed_op & divisor[WIDTH-1];
        a_mag     = a_neg ? -dividend : dividend;
        b_mag     = b_neg ? -divisor  : divisor;
        rem_sh    = {rem_reg, quo_reg[WIDTH-1]};
        trial     = rem_sh - {1'b0, dvs_reg};
        no_borrow = (rem_sh >= {1'b0, dvs_reg});
        rem_step  = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step  = {quo_reg[WIDTH-2:0], no_borrow};
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        dvs_next   = dvs_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        cnt_next   = cnt_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        unique case (state_reg)
            IDLE: begin
                if (start && !cancel) begin
                    neg_q_next = a_neg ^ b_neg;
                    neg_r_next = a_neg;
                    dvs_next   = b_mag;
                    quo_next   = a_mag;
                    rem_next   = '0;
                    cnt_next   = '0;
                    if (divisor == '0) begin
                        hi_next    = dividend;
                        lo_next    = '1;
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            DIV: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    rem_next = rem_step;
                    quo_next = quo_step;
                    cnt_next = cnt_reg + CNT_W'(1);
                    // Last step: apply sign fix-up straight into the HILO registers.
                    if (cnt_reg == CNT_W'(WIDTH-1)) begin
                        hi_next    = neg_r_reg ? -rem_step : rem_step;
                        lo_next    = neg_q_reg ? -quo_step : quo_step;
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == DIV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            dvs_reg   <= dvs_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            cnt_reg   <= cnt_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            busy_reg  <= busy_next;
        end
    end

    // Stall is gated by reset so an asserted start cannot stall a pipeline held in reset.
    assign stall_req        = rst & (((state_reg == IDLE) & start & ~cancel) |
                                     ((state_reg == DIV) & ~cancel));
    assign busy             = busy_reg;
    assign div_HILO_enabler = (state_reg == DONE) & ~cancel;
    assign div_HILO_HI      = hi_reg;
    assign div_HILO_LO      = lo_reg;

endmodule
